bomb_status_tracker: RTL and testbench
======================================

Name: bomb_status_tracker

Overview:
- Parametrised successor to the bomb mistake/solve bookkeeping block, generalised to N puzzle modules with a configurable chance table.
- Tracks per-module sticky solved flags and counts mistakes, with edge or level detection selected by parameter. Several simultaneous mistakes in one cycle are all counted.
- Runs a small outcome FSM (idle, armed, exploded, defused) that sits between the top-level game FSM and the LCD/7-seg status display.
- Drives the explode, all-solved, strike-pulse and remaining-chances ASCII outputs.

Parameters:
- N_MODULES, 5, number of puzzle modules (1..8).
- CNT_W, 4, mistake counter width; the counter saturates at 2^CNT_W-1.
- CHANCE_0, 5, allowed mistakes when mistake_chance=2'b00.
- CHANCE_1, 3, allowed mistakes when mistake_chance=2'b01.
- CHANCE_2, 1, allowed mistakes when mistake_chance=2'b10.
- CHANCE_3, 0, allowed mistakes when mistake_chance=2'b11.
- EDGE_DETECT, 1, 1 = count rising edges of mistake[i]; 0 = count every cycle mistake[i] is high.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- current_state  in  3  game FSM state: IDLE=000, ACTIVATING=001, ACTIVATED=010, others ignored
- mistake_chance  in  2  difficulty select, sampled during ACTIVATING
- time_out  in  1  countdown expired (level)
- solved  in  N_MODULES  per-module solved indication (level or pulse)
- mistake  in  N_MODULES  per-module mistake indication
- total_mistake_cnt  out  CNT_W  accumulated mistakes
- chance_left_ascii  out  8  ASCII digit of remaining chances
- solved_mask  out  N_MODULES  sticky solved flags
- all_solved  out  1  all modules solved (registered)
- explode  out  1  bomb exploded (registered, sticky)
- strike_pulse  out  1  one-cycle pulse on each clock edge where the count increases

Behaviour:
- Reset values:
  - All outputs are 0, except chance_left_ascii = "0" (8'd48).
  - total_chance = 0, FSM = T_IDLE, mistake history register = 0.
- Chance load: while current_state==ACTIVATING, total_chance <= CHANCE_n selected by mistake_chance. The value is held otherwise.
- FSM T_IDLE:
  - Counters and mask are held cleared.
  - Goes to T_ARMED when current_state==ACTIVATED.
- FSM T_ARMED: each cycle,
  - ev = (EDGE_DETECT ? mistake & ~mistake_d : mistake) & ~solved_mask. Mistakes from already-solved modules are ignored.
  - inc = popcount(ev), 0..N_MODULES.
  - next_cnt = min(cnt + inc, 2^CNT_W-1), computed at CNT_W+4 width before clamping.
  - strike_pulse <= (next_cnt != cnt).
  - next_mask = solved_mask | solved.
- Outcome evaluation in T_ARMED:
  - Explode condition is next_cnt > total_chance or time_out. It goes to T_EXPLODED and sets explode <= 1 on the same edge as the count update (latency 1 cycle from the mistake input).
  - Else, if next_mask is all ones, it goes to T_DEFUSED and sets all_solved <= 1.
  - If both conditions hold in the same cycle, explode wins and all_solved stays 0.
- T_EXPLODED / T_DEFUSED:
  - Terminal. Count, mask and flags are frozen; further mistake, solved and time_out inputs are ignored.
  - Returns to T_IDLE only when current_state==IDLE, clearing cnt, mask, explode, all_solved and the history register.
- current_state leaving ACTIVATED while in T_ARMED (e.g. pause): counts and mask hold, no events are counted, and the FSM stays in T_ARMED. current_state==IDLE from any state goes to T_IDLE and clears.
- mistake_d updates every cycle in all states, so that re-entering T_ARMED does not count an already-high level as an edge.
- chance_left = (cnt >= total_chance) ? 0 : total_chance - cnt. chance_left_ascii = 48 + min(chance_left, 9). This is combinational from registers.
- Asynchronous rst mid-game forces the reset values immediately; the FSM restarts from T_IDLE.

Test Plan:
- Chance table: mistake_chance=01, ACTIVATING then ACTIVATED -> chance_left_ascii=="3". One mistake[2] pulse -> cnt=1, strike_pulse high for 1 cycle, ascii "2".
- Simultaneous events: mistake=5'b10101 held for 3 cycles with EDGE_DETECT=1 -> cnt +3 exactly once. Rerun with EDGE_DETECT=0 -> +9, saturating at 15 when CNT_W=4.
- Explode threshold: chance=1 (10). Mistakes on cycles 10 and 20 -> explode rises on the edge after cycle 20, ascii "0". A later mistake leaves cnt at 2.
- Defuse and priority:
  - Solve modules 0..4 one at a time -> all_solved=1 on the edge after the last solve, and explode stays 0.
  - Separate run: last solve and time_out in the same cycle -> explode=1, all_solved=0.
- Masking/reset: module 1 solved, then mistake[1] pulses -> no count change. Assert rst mid-game -> all outputs return to reset values asynchronously. current_state=IDLE after explode -> cleared and re-armable.

Source files
------------

// File: rtl/bomb_status_tracker.sv
`default_nettype none
// ============================================================================
// Module   : bomb_status_tracker
// Purpose  : Per-module solve/mistake bookkeeping and outcome FSM for N modules.
// Revision : 1.0
// ============================================================================
module bomb_status_tracker #(
   parameter int N_MODULES   = 5,
   parameter int CNT_W       = 4,
   parameter int CHANCE_0    = 5,
   parameter int CHANCE_1    = 3,
   parameter int CHANCE_2    = 1,
   parameter int CHANCE_3    = 0,
   parameter int EDGE_DETECT = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [2:0]           current_state,
   input  logic [1:0]           mistake_chance,
   input  logic                 time_out,
   input  logic [N_MODULES-1:0] solved,
   input  logic [N_MODULES-1:0] mistake,
   output logic [CNT_W-1:0]     total_mistake_cnt,
   output logic [7:0]           chance_left_ascii,
   output logic [N_MODULES-1:0] solved_mask,
   output logic                 all_solved,
   output logic                 explode,
   output logic                 strike_pulse
);

   localparam int SUM_W = CNT_W + 4;
   localparam logic [SUM_W-1:0] c_CNT_MAX = SUM_W'((1 << CNT_W) - 1);
   localparam logic [2:0] c_GS_IDLE       = 3'b000;
   localparam logic [2:0] c_GS_ACTIVATING = 3'b001;
   localparam logic [2:0] c_GS_ACTIVATED  = 3'b010;

   typedef enum logic [1:0] {
      T_IDLE     = 2'd0,
      T_ARMED    = 2'd1,
      T_EXPLODED = 2'd2,
      T_DEFUSED  = 2'd3
   } track_state_t;

   track_state_t         r_state;
   logic [CNT_W-1:0]     r_cnt;
   logic [N_MODULES-1:0] r_mask;
   logic [N_MODULES-1:0] r_mistake_d;
   logic [SUM_W-1:0]     r_total_chance;
   logic                 r_explode;
   logic                 r_all_solved;
   logic                 r_strike;

   logic [N_MODULES-1:0] w_ev;
   logic [SUM_W-1:0]     w_inc;
   logic [SUM_W-1:0]     w_sum;
   logic [CNT_W-1:0]     w_next_cnt;
   logic [N_MODULES-1:0] w_next_mask;
   logic                 w_explode_cond;
   logic [SUM_W-1:0]     w_chance_sel;
   logic [SUM_W-1:0]     w_chance_left;
   logic [3:0]           w_chance_digit;

   always_comb begin
      w_ev = ((EDGE_DETECT != 0) ? (mistake & ~r_mistake_d) : mistake) & ~r_mask;
      w_inc = '0;
      for (int i = 0; i < N_MODULES; i++) begin
         w_inc = w_inc + SUM_W'(w_ev[i]);
      end
      // Sum is wide enough that a full burst of events cannot wrap before clamping
      w_sum          = SUM_W'(r_cnt) + w_inc;
      w_next_cnt     = (w_sum > c_CNT_MAX) ? c_CNT_MAX[CNT_W-1:0] : w_sum[CNT_W-1:0];
      w_next_mask    = r_mask | solved;
      w_explode_cond = (SUM_W'(w_next_cnt) > r_total_chance) || time_out;
   end

   always_comb begin
      case (mistake_chance)
         2'b00:   w_chance_sel = SUM_W'(CHANCE_0);
         2'b01:   w_chance_sel = SUM_W'(CHANCE_1);
         2'b10:   w_chance_sel = SUM_W'(CHANCE_2);
         default: w_chance_sel = SUM_W'(CHANCE_3);
      endcase
   end

   always_comb begin
      w_chance_left  = (SUM_W'(r_cnt) >= r_total_chance) ? '0 : (r_total_chance - SUM_W'(r_cnt));
      w_chance_digit = (w_chance_left > SUM_W'(9)) ? 4'd9 : w_chance_left[3:0];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state        <= T_IDLE;
         r_cnt          <= '0;
         r_mask         <= '0;
         r_mistake_d    <= '0;
         r_total_chance <= '0;
         r_explode      <= 1'b0;
         r_all_solved   <= 1'b0;
         r_strike       <= 1'b0;
      end else begin
         r_mistake_d <= mistake;
         r_strike    <= 1'b0;
         if (current_state == c_GS_ACTIVATING) begin
            r_total_chance <= w_chance_sel;
         end
         if (current_state == c_GS_IDLE) begin
            r_state      <= T_IDLE;
            r_cnt        <= '0;
            r_mask       <= '0;
            r_explode    <= 1'b0;
            r_all_solved <= 1'b0;
            if (r_state == T_EXPLODED || r_state == T_DEFUSED) begin
               r_mistake_d <= '0;
            end
         end else begin
            case (r_state)
               T_IDLE: begin
                  r_cnt  <= '0;
                  r_mask <= '0;
                  if (current_state == c_GS_ACTIVATED) begin
                     r_state <= T_ARMED;
                  end
               end
               T_ARMED: begin
                  // Any other game state pauses tracking without leaving T_ARMED
                  if (current_state == c_GS_ACTIVATED) begin
                     r_cnt    <= w_next_cnt;
                     r_mask   <= w_next_mask;
                     r_strike <= (w_next_cnt != r_cnt);
                     if (w_explode_cond) begin
                        r_state   <= T_EXPLODED;
                        r_explode <= 1'b1;
                     end else if (&w_next_mask) begin
                        r_state      <= T_DEFUSED;
                        r_all_solved <= 1'b1;
                     end
                  end
               end
               default: begin
               end
            endcase
         end
      end
   end

   assign total_mistake_cnt = r_cnt;
   assign solved_mask       = r_mask;
   assign all_solved        = r_all_solved;
   assign explode           = r_explode;
   assign strike_pulse      = r_strike;
   assign chance_left_ascii = 8'd48 + {4'd0, w_chance_digit};

endmodule
`default_nettype wire

// File: tb/tb_bomb_status_tracker.sv
`default_nettype none
// ============================================================================
// Module   : tb_bomb_status_tracker
// Purpose  : Bench for edge- and level-counting instances against a rule model.
// Revision : 1.0
// ============================================================================
module tb_bomb_status_tracker;

   localparam logic [2:0] c_IDLE  = 3'b000;
   localparam logic [2:0] c_ACTVG = 3'b001;
   localparam logic [2:0] c_ACTD  = 3'b010;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [2:0] cs = c_IDLE;
   logic [1:0] ch = 2'b00;
   logic       to = 1'b0;
   logic [4:0] sol = '0;
   logic [4:0] mis = '0;

   logic [1:0][3:0] d_cnt;
   logic [1:0][7:0] d_asc;
   logic [1:0][4:0] d_mask;
   logic [1:0]      d_all;
   logic [1:0]      d_expl;
   logic [1:0]      d_strk;

   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   bomb_status_tracker #(.EDGE_DETECT(1)) u_edge (
      .clk(clk), .rst(rst), .current_state(cs), .mistake_chance(ch), .time_out(to),
      .solved(sol), .mistake(mis), .total_mistake_cnt(d_cnt[0]), .chance_left_ascii(d_asc[0]),
      .solved_mask(d_mask[0]), .all_solved(d_all[0]), .explode(d_expl[0]), .strike_pulse(d_strk[0])
   );

   bomb_status_tracker #(.EDGE_DETECT(0), .CHANCE_0(15)) u_level (
      .clk(clk), .rst(rst), .current_state(cs), .mistake_chance(ch), .time_out(to),
      .solved(sol), .mistake(mis), .total_mistake_cnt(d_cnt[1]), .chance_left_ascii(d_asc[1]),
      .solved_mask(d_mask[1]), .all_solved(d_all[1]), .explode(d_expl[1]), .strike_pulse(d_strk[1])
   );

   // Reference model: game phase per instance (0 idle, 1 armed, 2 exploded, 3 defused)
   int       m_phase[2];
   int       m_cnt[2];
   int       m_tc[2];
   logic [4:0] m_mask[2];
   logic [4:0] m_md[2];
   bit       m_exp[2];
   bit       m_all[2];
   bit       m_strk[2];
   int       chance_tbl[2][4] = '{'{5, 3, 1, 0}, '{15, 3, 1, 0}};

   task automatic model_reset();
      for (int e = 0; e < 2; e++) begin
         m_phase[e] = 0; m_cnt[e] = 0; m_tc[e] = 0; m_mask[e] = '0; m_md[e] = '0;
         m_exp[e] = 0; m_all[e] = 0; m_strk[e] = 0;
      end
   endtask

   task automatic model_step();
      for (int e = 0; e < 2; e++) begin
         logic [4:0] nmd;
         logic [4:0] ev;
         int sum;
         nmd = mis;
         m_strk[e] = 0;
         if (cs == c_IDLE) begin
            if (m_phase[e] >= 2) nmd = '0;
            m_phase[e] = 0; m_cnt[e] = 0; m_mask[e] = '0; m_exp[e] = 0; m_all[e] = 0;
         end else if (m_phase[e] == 0) begin
            m_cnt[e] = 0; m_mask[e] = '0;
            if (cs == c_ACTD) m_phase[e] = 1;
         end else if (m_phase[e] == 1 && cs == c_ACTD) begin
            ev = ((e == 0) ? (mis & ~m_md[e]) : mis) & ~m_mask[e];
            sum = m_cnt[e] + $countones(ev);
            if (sum > 15) sum = 15;
            m_strk[e] = (sum != m_cnt[e]);
            m_cnt[e] = sum;
            m_mask[e] = m_mask[e] | sol;
            if (sum > m_tc[e] || to) begin
               m_phase[e] = 2; m_exp[e] = 1;
            end else if (m_mask[e] == 5'h1F) begin
               m_phase[e] = 3; m_all[e] = 1;
            end
         end
         if (cs == c_ACTVG) m_tc[e] = chance_tbl[e][ch];
         m_md[e] = nmd;
      end
   endtask

   function automatic int model_ascii(int e);
      int left;
      left = (m_cnt[e] >= m_tc[e]) ? 0 : m_tc[e] - m_cnt[e];
      if (left > 9) left = 9;
      return 48 + left;
   endfunction

   task automatic chk(string name, int act, int exp);
      n_chk++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic check_all();
      for (int e = 0; e < 2; e++) begin
         chk($sformatf("cnt[%0d]", e),   int'(d_cnt[e]),  m_cnt[e]);
         chk($sformatf("ascii[%0d]", e), int'(d_asc[e]),  model_ascii(e));
         chk($sformatf("mask[%0d]", e),  int'(d_mask[e]), int'(m_mask[e]));
         chk($sformatf("all[%0d]", e),   int'(d_all[e]),  int'(m_all[e]));
         chk($sformatf("expl[%0d]", e),  int'(d_expl[e]), int'(m_exp[e]));
         chk($sformatf("strk[%0d]", e),  int'(d_strk[e]), int'(m_strk[e]));
      end
   endtask

   task automatic cycle();
      if (rst) model_reset(); else model_step();
      @(posedge clk);
      #1;
      check_all();
   endtask

   task automatic arm(input logic [1:0] sel);
      mis = '0; sol = '0; to = 1'b0;
      cs = c_IDLE;  cycle();
      cs = c_ACTVG; ch = sel; cycle();
      cs = c_ACTD;  cycle();
   endtask

   typedef struct packed {
      logic [2:0] cs;
      logic [1:0] ch;
      logic [4:0] sol;
      logic [4:0] mis;
      logic [3:0] cnt;
      logic [7:0] asc;
      logic       expl;
      logic       strk;
   } vec_t;

   vec_t tbl[16];

   initial begin
      tbl[0]  = '{c_IDLE,  2'b01, 5'b00000, 5'b00000, 4'd0, 8'd48, 1'b0, 1'b0};
      tbl[1]  = '{c_ACTVG, 2'b01, 5'b00000, 5'b00000, 4'd0, 8'd51, 1'b0, 1'b0};
      tbl[2]  = '{c_ACTD,  2'b01, 5'b00000, 5'b00000, 4'd0, 8'd51, 1'b0, 1'b0};
      tbl[3]  = '{c_ACTD,  2'b01, 5'b00000, 5'b00100, 4'd1, 8'd50, 1'b0, 1'b1};
      tbl[4]  = '{c_ACTD,  2'b01, 5'b00000, 5'b00000, 4'd1, 8'd50, 1'b0, 1'b0};
      tbl[5]  = '{c_ACTD,  2'b01, 5'b00010, 5'b00000, 4'd1, 8'd50, 1'b0, 1'b0};
      tbl[6]  = '{c_ACTD,  2'b01, 5'b00000, 5'b00010, 4'd1, 8'd50, 1'b0, 1'b0};
      tbl[7]  = '{3'b011,  2'b01, 5'b00000, 5'b00001, 4'd1, 8'd50, 1'b0, 1'b0};
      tbl[8]  = '{c_ACTD,  2'b01, 5'b00000, 5'b00000, 4'd1, 8'd50, 1'b0, 1'b0};
      tbl[9]  = '{c_ACTD,  2'b01, 5'b00000, 5'b00001, 4'd2, 8'd49, 1'b0, 1'b1};
      tbl[10] = '{c_ACTD,  2'b01, 5'b00000, 5'b00000, 4'd2, 8'd49, 1'b0, 1'b0};
      tbl[11] = '{c_ACTD,  2'b01, 5'b00000, 5'b01000, 4'd3, 8'd48, 1'b0, 1'b1};
      tbl[12] = '{c_ACTD,  2'b01, 5'b00000, 5'b00000, 4'd3, 8'd48, 1'b0, 1'b0};
      tbl[13] = '{c_ACTD,  2'b01, 5'b00000, 5'b10000, 4'd4, 8'd48, 1'b1, 1'b1};
      tbl[14] = '{c_ACTD,  2'b01, 5'b00000, 5'b00001, 4'd4, 8'd48, 1'b1, 1'b0};
      tbl[15] = '{c_IDLE,  2'b01, 5'b00000, 5'b00000, 4'd0, 8'd51, 1'b0, 1'b0};

      // Reset state
      rst = 1'b1;
      model_reset();
      #2;
      chk("rst_cnt", int'(d_cnt[0]), 0);
      chk("rst_ascii", int'(d_asc[0]), 48);
      chk("rst_expl", int'(d_expl[0]), 0);
      cycle();
      cycle();
      rst = 1'b0;

      // Chance table, masking, pause and explode via vector table
      for (int i = 0; i < 16; i++) begin
         cs = tbl[i].cs; ch = tbl[i].ch; sol = tbl[i].sol; mis = tbl[i].mis; to = 1'b0;
         cycle();
         chk($sformatf("tbl%0d_cnt", i),   int'(d_cnt[0]),  int'(tbl[i].cnt));
         chk($sformatf("tbl%0d_ascii", i), int'(d_asc[0]),  int'(tbl[i].asc));
         chk($sformatf("tbl%0d_expl", i),  int'(d_expl[0]), int'(tbl[i].expl));
         chk($sformatf("tbl%0d_strk", i),  int'(d_strk[0]), int'(tbl[i].strk));
      end

      // Simultaneous events: edge counts once, level counts every cycle and saturates
      arm(2'b00);
      mis = 5'b10101;
      repeat (3) cycle();
      mis = '0; cycle();
      chk("simul_edge_cnt", int'(d_cnt[0]), 3);
      chk("simul_level_cnt", int'(d_cnt[1]), 9);
      mis = 5'b10101;
      repeat (3) cycle();
      mis = '0;
      chk("sat_level_cnt", int'(d_cnt[1]), 15);
      chk("sat_level_expl", int'(d_expl[1]), 0);
      chk("repress_edge_expl", int'(d_expl[0]), 1);

      // Explode threshold with one allowed mistake
      arm(2'b10);
      for (int i = 1; i <= 25; i++) begin
         mis = (i == 10 || i == 20 || i == 23) ? 5'b00001 : 5'b00000;
         cycle();
         if (i == 19) chk("thr_before_expl", int'(d_expl[0]), 0);
         if (i == 20) begin
            chk("thr_expl", int'(d_expl[0]), 1);
            chk("thr_ascii", int'(d_asc[0]), 48);
         end
      end
      chk("thr_frozen_cnt", int'(d_cnt[0]), 2);

      // Defuse by solving each module in turn
      arm(2'b00);
      for (int b = 0; b < 5; b++) begin
         sol = 5'(1 << b);
         cycle();
         chk($sformatf("defuse_all_b%0d", b), int'(d_all[0]), (b == 4) ? 1 : 0);
      end
      sol = '0; cycle();
      chk("defuse_expl", int'(d_expl[0]), 0);

      // Last solve coincides with time_out: explode takes priority
      arm(2'b00);
      for (int b = 0; b < 4; b++) begin
         sol = 5'(1 << b); cycle();
      end
      sol = 5'b10000; to = 1'b1; cycle();
      sol = '0; to = 1'b0;
      chk("prio_expl", int'(d_expl[0]), 1);
      chk("prio_all", int'(d_all[0]), 0);

      // Asynchronous reset mid-game
      arm(2'b01);
      mis = 5'b00011; cycle();
      mis = '0;
      #2 rst = 1'b1;
      model_reset();
      #1;
      chk("arst_cnt", int'(d_cnt[0]), 0);
      chk("arst_ascii", int'(d_asc[0]), 48);
      check_all();
      cycle();
      rst = 1'b0;

      // Re-arm after reset
      arm(2'b01);
      mis = 5'b01000; cycle();
      mis = '0;
      chk("rearm_cnt", int'(d_cnt[0]), 1);

      // Randomized traffic against the model
      for (int i = 0; i < 3000; i++) begin
         int r;
         r = $urandom_range(0, 99);
         if (r < 3)       cs = c_IDLE;
         else if (r < 6)  cs = c_ACTVG;
         else if (r < 9)  cs = 3'($urandom_range(3, 7));
         else             cs = c_ACTD;
         ch  = 2'($urandom_range(0, 3));
         mis = 5'($urandom & $urandom & $urandom);
         sol = 5'($urandom & $urandom & $urandom & $urandom);
         to  = ($urandom_range(0, 199) == 0);
         cycle();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
`default_nettype wire
